// File: rtl/i2s_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | i2s_pkg : shared types and constants for the I2S receiver           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package i2s_pkg;

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_t;

  localparam int BITCNT_W   = 6;
  localparam int BITCNT_MAX = 63;

endpackage
`default_nettype wire

// File: rtl/i2s_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | i2s_rx_if : I2S pins plus the deserialized stereo sample bus        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface i2s_rx_if #(
  parameter int WIDTH = 16
);
  logic             bclk;
  logic             lrclk;
  logic             sdata;
  logic [WIDTH-1:0] left_out;
  logic [WIDTH-1:0] right_out;
  logic             sample_valid;
  logic             frame_err;

  modport master (
    output bclk, lrclk, sdata,
    input  left_out, right_out, sample_valid, frame_err
  );

  modport slave (
    input  bclk, lrclk, sdata,
    output left_out, right_out, sample_valid, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/i2s_sync.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | i2s_sync : multi-flop pin synchronizer, optional registered rise    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module i2s_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_EN     = 1'b0
) (
  input  wire logic clk,
  input  wire logic reset_n,
  input  wire logic i_d,
  output logic      o_q,
  output logic      o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic r_prev;
      logic r_rise;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_prev <= 1'b0;
          r_rise <= 1'b0;
        end else begin
          r_prev <= o_q;
          r_rise <= o_q & ~r_prev;
        end
      end

      assign o_rise = r_rise;
    end else begin : g_no_edge
      assign o_rise = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/i2s_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | i2s_rx : oversampled Philips I2S receiver, 16-bit stereo pairs      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input wire logic clk,
  input wire logic reset_n,
  i2s_rx_if.slave  bus
);

  logic w_tick, w_lr, w_sd, w_bclk_q, w_lr_rise, w_sd_rise;
  logic w_unused_sync;

  i2s_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_bclk (
    .clk(clk), .reset_n(reset_n), .i_d(bus.bclk), .o_q(w_bclk_q), .o_rise(w_tick)
  );
  i2s_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_lrclk (
    .clk(clk), .reset_n(reset_n), .i_d(bus.lrclk), .o_q(w_lr), .o_rise(w_lr_rise)
  );
  i2s_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_sdata (
    .clk(clk), .reset_n(reset_n), .i_d(bus.sdata), .o_q(w_sd), .o_rise(w_sd_rise)
  );

  assign w_unused_sync = &{1'b0, w_bclk_q, w_lr_rise, w_sd_rise};

  i2s_state_t            r_state, w_state_nxt;
  logic [BITCNT_W-1:0]   r_bit_cnt, w_cnt_inc;
  logic [WIDTH-1:0]      r_shift, r_left_hold, r_left_out, r_right_out;
  logic                  r_lr_prev, r_valid, r_err;
  logic                  w_trans, w_short, w_latch_left, w_emit, w_err;

  // A transition tick carries the LSB of the slot that is ending.
  assign w_trans   = w_tick & (w_lr ^ r_lr_prev);
  assign w_short   = r_bit_cnt < BITCNT_W'(WIDTH);
  assign w_cnt_inc = (r_bit_cnt == BITCNT_W'(BITCNT_MAX)) ? r_bit_cnt : r_bit_cnt + 1'b1;

  always_comb begin
    w_state_nxt  = r_state;
    w_latch_left = 1'b0;
    w_emit       = 1'b0;
    w_err        = 1'b0;
    if (w_trans) begin
      case (r_state)
        ALIGN: if (!w_lr) w_state_nxt = LEFT;
        LEFT: if (w_lr) begin
          if (w_short) begin
            w_err       = 1'b1;
            w_state_nxt = ALIGN;
          end else begin
            w_latch_left = 1'b1;
            w_state_nxt  = RIGHT;
          end
        end
        RIGHT: if (!w_lr) begin
          if (w_short) begin
            w_err       = 1'b1;
            w_state_nxt = ALIGN;
          end else begin
            w_emit      = 1'b1;
            w_state_nxt = LEFT;
          end
        end
        default: w_state_nxt = ALIGN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ALIGN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_left_hold <= '0;
      r_lr_prev   <= 1'b0;
      r_left_out  <= '0;
      r_right_out <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_valid <= w_emit;
      r_err   <= w_err;
      if (w_tick) begin
        r_lr_prev <= w_lr;
        if (w_trans) begin
          r_bit_cnt <= '0;
        end else begin
          r_bit_cnt <= w_cnt_inc;
          // Bits past WIDTH are dropped, truncating wider slots.
          if (w_cnt_inc <= BITCNT_W'(WIDTH)) begin
            r_shift <= {r_shift[WIDTH-2:0], w_sd};
          end
        end
      end
      if (w_latch_left) begin
        r_left_hold <= r_shift;
      end
      if (w_emit) begin
        r_left_out  <= r_left_hold;
        r_right_out <= r_shift;
      end
    end
  end

  assign bus.left_out     = r_left_out;
  assign bus.right_out    = r_right_out;
  assign bus.sample_valid = r_valid;
  assign bus.frame_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_i2s_rx : scoreboard bench, directed I2S frames at clk = 8x bclk  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_i2s_rx;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  i2s_rx_if #(.WIDTH(16)) bus ();

  i2s_rx #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int          total = 0;
  int          bad = 0;
  int          n_valid = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          err_q[$];
  logic [15:0] hold_l = '0;
  logic [15:0] hold_r = '0;
  time         t_edge = 0;
  logic        lr_cur = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // Data and word select change while bclk is low; receiver samples on the rise.
  task automatic send_bit(input logic lr, input logic d);
    bus.bclk  = 1'b0;
    bus.lrclk = lr;
    bus.sdata = d;
    #40;
    bus.bclk = 1'b1;
    if (lr_cur && !lr) t_edge = $time;
    lr_cur = lr;
    #40;
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r,
                            input int nl, input int nr, input bit exp_valid,
                            input logic [15:0] el, input logic [15:0] er, input bit exp_err);
    if (exp_err) err_q.push_back(1);
    for (int i = nl - 1; i >= 1; i--) send_bit(1'b0, l[i]);
    send_bit(1'b1, l[0]);
    for (int i = nr - 1; i >= 1; i--) begin
      send_bit(1'b1, r[i]);
      if (exp_valid && i == nr - 4) exp_q.push_back({el, er});
    end
    send_bit(1'b0, r[0]);
  endtask

  initial begin : monitor
    logic [31:0] e;
    int          lat;
    forever begin
      @(negedge clk);
      if (bus.sample_valid) begin
        n_valid++;
        check("valid_excl_err", {31'd0, bus.frame_err}, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got L=%h R=%h expected no pulse at %0t",
                   bus.left_out, bus.right_out, $time);
        end else begin
          e = exp_q.pop_front();
          check("left_out", {16'd0, bus.left_out}, {16'd0, e[31:16]});
          check("right_out", {16'd0, bus.right_out}, {16'd0, e[15:0]});
          lat = int'(($time - t_edge) / 10);
          check_range("latency", lat, 4, 5);
          hold_l = e[31:16];
          hold_r = e[15:0];
        end
      end
      if (bus.frame_err) begin
        n_err++;
        if (err_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame_err: got pulse expected none at %0t", $time);
        end else begin
          void'(err_q.pop_front());
          check("err_hold_left", {16'd0, bus.left_out}, {16'd0, hold_l});
          check("err_hold_right", {16'd0, bus.right_out}, {16'd0, hold_r});
        end
      end
    end
  end

  initial begin : stimulus
    logic [31:0] l_int;
    logic [31:0] r_int;
    bus.bclk  = 1'b0;
    bus.lrclk = 1'b0;
    bus.sdata = 1'b0;
    reset_n   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_left", {16'd0, bus.left_out}, 32'd0);
    check("rst_right", {16'd0, bus.right_out}, 32'd0);
    check("rst_valid", {31'd0, bus.sample_valid}, 32'd0);
    check("rst_err", {31'd0, bus.frame_err}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Join mid-right-slot, then three full frames.
    for (int i = 0; i < 5; i++) send_bit(1'b1, i[0]);
    send_bit(1'b0, 1'b1);
    send_frame(32'h1234_0F0F, 32'hABCD_5555, 32, 32, 1'b1, 16'h1234, 16'hABCD, 1'b0);
    send_frame(32'h5A5A_FFFF, 32'h0F0F_0000, 32, 32, 1'b1, 16'h5A5A, 16'h0F0F, 1'b0);
    send_frame(32'h0080_0155, 32'h007F_FFFF, 24, 24, 1'b1, 16'h8001, 16'h7FFF, 1'b0);
    repeat (10) @(negedge clk);
    check("startup_valid_count", n_valid, 32'd3);

    send_frame(32'h0000_0ABC, 32'h1234_5678, 12, 32, 1'b0, 16'h0, 16'h0, 1'b1);
    send_frame(32'h0001_8000, 32'hFFFF_0001, 32, 32, 1'b1, 16'h0001, 16'hFFFF, 1'b0);
    repeat (10) @(negedge clk);
    check("short_err_count", n_err, 32'd1);

    l_int = 32'hC3C3_3C3C;
    r_int = 32'h9999_6666;
    for (int i = 31; i >= 22; i--) send_bit(1'b0, l_int[i]);
    reset_n = 1'b0;
    hold_l  = '0;
    hold_r  = '0;
    #1;
    check("midrst_left", {16'd0, bus.left_out}, 32'd0);
    check("midrst_right", {16'd0, bus.right_out}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 21; i >= 1; i--) send_bit(1'b0, l_int[i]);
    send_bit(1'b1, l_int[0]);
    for (int i = 31; i >= 1; i--) send_bit(1'b1, r_int[i]);
    send_bit(1'b0, r_int[0]);
    send_frame(32'h7FFF_0000, 32'h8000_FFFF, 32, 32, 1'b1, 16'h7FFF, 16'h8000, 1'b0);

    repeat (20) @(negedge clk);
    check("valid_queue_empty", exp_q.size(), 32'd0);
    check("err_queue_empty", err_q.size(), 32'd0);
    check("total_valid_count", n_valid, 32'd5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
